// File: rtl/fetch_stage_pkg.sv
// Shared constants and state type for the instruction fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } fetchState_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble is inserted.
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_pc,
    input  logic [31:0]     i_instr,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pcPlus4,
    output logic [31:0]     o_instr
);

    logic            r_valid;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pcPlus4;
    logic [31:0]     r_instr;

    // Bubbles and flushes only kill valid/instruction; the PC fields keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_pcPlus4 <= XLEN'(4);
            r_instr   <= NOP_INSTR;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (!i_stall) begin
            if (i_load) begin
                r_valid   <= 1'b1;
                r_pc      <= i_pc;
                r_pcPlus4 <= i_pc + XLEN'(4);
                r_instr   <= i_instr;
            end else begin
                r_valid <= 1'b0;
                r_instr <= NOP_INSTR;
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_pc      = r_pc;
    assign o_pcPlus4 = r_pcPlus4;
    assign o_instr   = r_instr;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps one request in flight, absorbs a stalled response
// in a one-entry skid buffer and feeds the IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_pc_plus4,
    output logic [31:0]     if_id_instruction
);

    fetchState_t     r_state;
    fetchState_t     w_nextState;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_pendPc;
    logic [XLEN-1:0] r_skidPc;
    logic [31:0]     r_skidInstr;
    logic [XLEN-1:0] w_redirectPc;
    logic [XLEN-1:0] w_loadPc;
    logic [31:0]     w_loadInstr;
    logic            w_accept;
    logic            w_load;
    logic            w_skidCapture;

    assign w_accept      = (r_state == ST_REQ) && imem_req_ready;
    assign w_redirectPc  = redirect_pc & ~XLEN'(3);
    assign w_skidCapture = (r_state == ST_WAIT) && imem_rsp_valid && stall && !redirect_valid;

    // A redirect that races an accepted request or an unanswered one must swallow that response (DROP).
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_loadPc    = r_pendPc;
        w_loadInstr = imem_rdata;
        case (r_state)
            ST_IDLE: w_nextState = ST_REQ;
            ST_REQ: begin
                if (imem_req_ready)
                    w_nextState = redirect_valid ? ST_DROP : ST_WAIT;
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    w_nextState = imem_rsp_valid ? ST_REQ : ST_DROP;
                end else if (imem_rsp_valid) begin
                    if (stall) begin
                        w_nextState = ST_HOLD;
                    end else begin
                        w_load      = 1'b1;
                        w_nextState = ST_REQ;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    w_nextState = ST_REQ;
                end else if (!stall) begin
                    w_load      = 1'b1;
                    w_loadPc    = r_skidPc;
                    w_loadInstr = r_skidInstr;
                    w_nextState = ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_rsp_valid)
                    w_nextState = ST_REQ;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_pc        <= RESET_PC;
            r_pendPc    <= '0;
            r_skidPc    <= '0;
            r_skidInstr <= NOP_INSTR;
        end else begin
            r_state <= w_nextState;
            if (redirect_valid)
                r_pc <= w_redirectPc;
            else if (w_accept)
                r_pc <= r_pc + XLEN'(4);
            if (w_accept)
                r_pendPc <= r_pc;
            if (w_skidCapture) begin
                r_skidPc    <= r_pendPc;
                r_skidInstr <= imem_rdata;
            end
        end
    end

    assign imem_req_valid = (r_state == ST_REQ);
    assign imem_addr      = r_pc;

    fetch_stage_if_id_reg #(
        .XLEN (XLEN)
    ) u_ifIdReg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_stall   (stall),
        .i_flush   (redirect_valid),
        .i_pc      (w_loadPc),
        .i_instr   (w_loadInstr),
        .o_valid   (if_id_valid),
        .o_pc      (if_id_pc),
        .o_pcPlus4 (if_id_pc_plus4),
        .o_instr   (if_id_instruction)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-programmable memory, transaction-level fetch model, directed scenarios.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instruction;

    int compareCount = 0;
    int failCount    = 0;

    fetch_stage #(
        .XLEN     (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_addr         (imem_addr),
        .imem_rsp_valid    (imem_rsp_valid),
        .imem_rdata        (imem_rdata),
        .stall             (stall),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .if_id_valid       (if_id_valid),
        .if_id_pc          (if_id_pc),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_instruction (if_id_instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory side: answers every accepted request memLatency cycles later.
    bit          memPending;
    int          memWait;
    int          memLatency = 1;
    logic [31:0] memAddr;

    function automatic logic [31:0] memData(input logic [31:0] addr);
        return addr + 32'hA000_0001;
    endfunction

    // Fetch model: next PC, one in-flight request (possibly killed), one parked response, IF/ID contents.
    bit          modelLive;
    bit          pendingStep;
    logic        mStarted;
    logic        mOut;
    logic        mKilled;
    logic        mSkidFull;
    logic [31:0] mPc;
    logic [31:0] mOutAddr;
    logic [31:0] mSkidPc;
    logic [31:0] mSkidInstr;
    logic        mIfValid;
    logic [31:0] mIfPc;
    logic [31:0] mIfInstr;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mStarted  = 1'b0;
        mOut      = 1'b0;
        mKilled   = 1'b0;
        mSkidFull = 1'b0;
        mPc       = RESET_PC;
        mIfValid  = 1'b0;
        mIfPc     = 32'h0;
        mIfInstr  = NOP;
        modelLive = 1'b1;
    endtask

    task automatic modelStep();
        logic        accept;
        logic        deliver;
        logic [31:0] dPc;
        logic [31:0] dInstr;
        accept  = mStarted && !mOut && !mSkidFull && imem_req_ready;
        deliver = 1'b0;
        dPc     = 32'h0;
        dInstr  = NOP;
        if (redirect_valid) begin
            if (accept) begin
                mOut    = 1'b1;
                mKilled = 1'b1;
            end else if (mOut && imem_rsp_valid) begin
                mOut = 1'b0;
            end else if (mOut) begin
                mKilled = 1'b1;
            end
            mSkidFull = 1'b0;
            mPc       = {redirect_pc[31:2], 2'b00};
            mIfValid  = 1'b0;
            mIfInstr  = NOP;
        end else begin
            if (mSkidFull && !stall) begin
                deliver   = 1'b1;
                dPc       = mSkidPc;
                dInstr    = mSkidInstr;
                mSkidFull = 1'b0;
            end else if (mOut && imem_rsp_valid) begin
                mOut = 1'b0;
                if (!mKilled) begin
                    if (stall) begin
                        mSkidFull  = 1'b1;
                        mSkidPc    = mOutAddr;
                        mSkidInstr = imem_rdata;
                    end else begin
                        deliver = 1'b1;
                        dPc     = mOutAddr;
                        dInstr  = imem_rdata;
                    end
                end
            end
            if (accept) begin
                mOut     = 1'b1;
                mKilled  = 1'b0;
                mOutAddr = mPc;
                mPc      = mPc + 32'd4;
            end
            if (!stall) begin
                mIfValid = deliver;
                mIfInstr = deliver ? dInstr : NOP;
                if (deliver)
                    mIfPc = dPc;
            end
        end
        mStarted = 1'b1;
    endtask

    // One clock cycle: settle the model for the previous cycle, then drive this cycle's inputs.
    task automatic applyStimulus(input logic ready, input logic stl, input logic rv, input logic [31:0] rpc);
        if (pendingStep)
            modelStep();
        @(negedge clk);
        #1;
        imem_req_ready = ready;
        stall          = stl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_rsp_valid = 1'b0;
        imem_rdata     = 32'hDEAD_BEEF;
        if (memPending) begin
            if (memWait == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rdata     = memData(memAddr);
                memPending     = 1'b0;
            end else begin
                memWait--;
            end
        end
        if (imem_req_valid && ready) begin
            memPending = 1'b1;
            memAddr    = imem_addr;
            memWait    = memLatency - 1;
        end
        pendingStep = 1'b1;
    endtask

    task automatic doReset();
        if (pendingStep)
            modelStep();
        pendingStep = 1'b0;
        @(negedge clk);
        #1;
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rdata     = 32'h0;
        memPending     = 1'b0;
        memLatency     = 1;
        modelReset();
        #1;
        checkOutput("rstReqValid", 32'(imem_req_valid), 32'h0);
        checkOutput("rstAddr", imem_addr, RESET_PC);
        checkOutput("rstIfIdValid", 32'(if_id_valid), 32'h0);
        checkOutput("rstIfIdPc", if_id_pc, 32'h0);
        checkOutput("rstIfIdPc4", if_id_pc_plus4, 32'h4);
        checkOutput("rstIfIdInstr", if_id_instruction, NOP);
        @(negedge clk);
        #1;
        rst_n       = 1'b1;
        pendingStep = 1'b1;
    endtask

    task automatic expectReq(input logic v, input logic [31:0] addr);
        checkOutput("litReqValid", 32'(imem_req_valid), 32'(v));
        checkOutput("modelReqValid", 32'(mStarted && !mOut && !mSkidFull), 32'(v));
        if (v) begin
            checkOutput("litReqAddr", imem_addr, addr);
            checkOutput("modelReqAddr", mPc, addr);
        end
    endtask

    task automatic expectIfId(input logic v, input logic [31:0] pc, input logic [31:0] instr);
        checkOutput("litIfIdValid", 32'(if_id_valid), 32'(v));
        checkOutput("modelIfIdValid", 32'(mIfValid), 32'(v));
        checkOutput("litIfIdInstr", if_id_instruction, v ? instr : NOP);
        if (v) begin
            checkOutput("litIfIdPc", if_id_pc, pc);
            checkOutput("litIfIdPc4", if_id_pc_plus4, pc + 32'd4);
            checkOutput("modelIfIdPc", mIfPc, pc);
        end
    endtask

    // Cycle-by-cycle comparison against the model whenever the DUT is out of reset.
    always @(negedge clk) begin : compareProc
        logic expReq;
        if (rst_n && modelLive) begin
            expReq = mStarted && !mOut && !mSkidFull;
            checkOutput("reqValid", 32'(imem_req_valid), 32'(expReq));
            if (expReq)
                checkOutput("reqAddr", imem_addr, mPc);
            checkOutput("ifIdValid", 32'(if_id_valid), 32'(mIfValid));
            checkOutput("ifIdInstr", if_id_instruction, mIfInstr);
            if (mIfValid) begin
                checkOutput("ifIdPc", if_id_pc, mIfPc);
                checkOutput("ifIdPc4", if_id_pc_plus4, mIfPc + 32'd4);
            end
        end
    end

    initial begin
        rst_n          = 1'b1;
        imem_req_ready = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rdata     = 32'h0;
        modelLive      = 1'b0;
        pendingStep    = 1'b0;
        memPending     = 1'b0;

        $display("[TB] streaming fetch, zero-wait memory");
        doReset();
        applyStimulus(1, 0, 0, 0); expectReq(1, 32'h100); expectIfId(0, 0, 0);
        applyStimulus(1, 0, 0, 0); expectReq(0, 0);
        applyStimulus(1, 0, 0, 0); expectReq(1, 32'h104); expectIfId(1, 32'h100, 32'hA000_0101);
        applyStimulus(1, 0, 0, 0); expectIfId(0, 0, 0);
        applyStimulus(1, 0, 0, 0); expectReq(1, 32'h108); expectIfId(1, 32'h104, 32'hA000_0105);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0); expectIfId(1, 32'h108, 32'hA000_0109);

        $display("[TB] stall across the 0x104 response");
        doReset();
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0); expectIfId(1, 32'h100, 32'hA000_0101); expectReq(1, 32'h104);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 0); expectIfId(1, 32'h100, 32'hA000_0101); expectReq(0, 0);
        end
        applyStimulus(1, 0, 0, 0); expectIfId(1, 32'h100, 32'hA000_0101); expectReq(0, 0);
        applyStimulus(1, 0, 0, 0); expectIfId(1, 32'h104, 32'hA000_0105); expectReq(1, 32'h108);

        $display("[TB] redirect while waiting on a slow 0x108");
        doReset();
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 0, 0, 0);
        memLatency = 3;
        applyStimulus(1, 1, 0, 0);          expectReq(1, 32'h108); expectIfId(1, 32'h104, 32'hA000_0105);
        applyStimulus(1, 1, 1, 32'h200);    expectReq(0, 0);       expectIfId(1, 32'h104, 32'hA000_0105);
        applyStimulus(1, 0, 0, 0);          expectReq(0, 0);       expectIfId(0, 0, 0);
        applyStimulus(1, 0, 0, 0);          expectReq(0, 0);
        memLatency = 1;
        applyStimulus(1, 0, 0, 0);          expectReq(1, 32'h200); expectIfId(0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);          expectIfId(1, 32'h200, 32'hA000_0201);

        $display("[TB] redirect coincident with a response");
        doReset();
        applyStimulus(1, 0, 0, 0);          expectReq(1, 32'h100);
        applyStimulus(1, 0, 1, 32'h301);    expectReq(0, 0);
        applyStimulus(1, 0, 0, 0);          expectReq(1, 32'h300); expectIfId(0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);          expectIfId(1, 32'h300, 32'hA000_0301);

        $display("[TB] memory back-pressure on 0x104");
        doReset();
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0); expectReq(1, 32'h104);
        end
        applyStimulus(1, 0, 0, 0); expectReq(1, 32'h104);
        applyStimulus(1, 0, 0, 0); expectReq(0, 0);
        applyStimulus(1, 0, 0, 0); expectIfId(1, 32'h104, 32'hA000_0105);

        $display("[TB] PC wrap and reset during WAIT");
        doReset();
        applyStimulus(0, 0, 1, 32'hFFFF_FFFC); expectReq(1, 32'h100);
        applyStimulus(1, 0, 0, 0);             expectReq(1, 32'hFFFF_FFFC);
        applyStimulus(1, 0, 0, 0);
        memLatency = 3;
        applyStimulus(1, 0, 0, 0);             expectReq(1, 32'h0); expectIfId(1, 32'hFFFF_FFFC, 32'h9FFF_FFFD);
        checkOutput("wrapPcPlus4", if_id_pc_plus4, 32'h0);
        applyStimulus(1, 0, 0, 0);             expectReq(0, 0);
        doReset();

        $display("[TB] mixed stall / back-pressure / redirect pattern");
        for (int i = 0; i < 160; i++) begin
            memLatency = 1 + (i % 3);
            applyStimulus((i % 4) != 3, ((i % 7) == 3) || ((i % 7) == 4), (i % 13) == 6,
                          32'h400 + 32'(i * 8) + 32'(i % 4));
        end
        applyStimulus(1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
